// File: rtl/pulse_stretch_nch.sv
// Multi-channel rising-edge detector and pulse stretcher for fast-to-slow event transfer.
// Latency: edge sampled at clk edge k -> stretch_out high k+1..k+STRETCH (+2 with PSTR_INPUT_SYNC_EN).
// No backpressure: edges arriving while active either retrigger (RETRIG=1) or are dropped and flagged.
module pulse_stretch_nch #(
  parameter int CH      = 4,
  parameter int STRETCH = 6,
  parameter int RETRIG  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  input  logic [CH-1:0] drop_clr,
  output logic [CH-1:0] stretch_out,
  output logic [CH-1:0] rise_out,
  output logic [CH-1:0] drop_flag,
  output logic          busy
);

  localparam int CW = $clog2(STRETCH + 1);

  logic          retrig_en;
  logic [CH-1:0] din_s;
  logic [CH-1:0] din_q, din_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic [CH-1:0] stretch_q, stretch_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] drop_q, drop_d;
  logic          busy_q, busy_d;
  logic [CH-1:0] rise, active, accept;

  assign retrig_en = (RETRIG != 0);

`ifdef PSTR_INPUT_SYNC_EN
  // Two-flop synchroniser; din may be asynchronous to clk.
  logic [CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = din;
`endif

  always_comb begin
    din_d     = din_s;
    rise      = '0;
    active    = '0;
    accept    = '0;
    stretch_d = '0;
    rise_d    = '0;
    drop_d    = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]  = '0;
      rise[i]   = din_s[i] & ~din_q[i];
      active[i] = (cnt_q[i] != '0);
      accept[i] = rise[i] & (~active[i] | retrig_en);
      if (accept[i]) begin
        cnt_d[i]     = CW'(STRETCH);
        stretch_d[i] = 1'b1;
        rise_d[i]    = 1'b1;
      end else if (active[i]) begin
        cnt_d[i]     = cnt_q[i] - CW'(1);
        stretch_d[i] = (cnt_q[i] > CW'(1));
      end
      // A set in the same cycle as drop_clr keeps the flag.
      drop_d[i] = ~retrig_en & ((rise[i] & active[i]) | (drop_q[i] & ~drop_clr[i]));
    end
    busy_d = |stretch_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q     <= '0;
      stretch_q <= '0;
      rise_q    <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      din_q     <= din_d;
      stretch_q <= stretch_d;
      rise_q    <= rise_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stretch_out = stretch_q;
  assign rise_out    = rise_q;
  assign drop_flag   = retrig_en ? '0 : drop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_stretch_nch.sv
// Bench for pulse_stretch_nch: two instances (RETRIG=0 and RETRIG=1) share stimulus, CH=4, STRETCH=6.
module tb_pulse_stretch_nch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] drop_clr;
  logic [3:0] s0, r0, d0, s1, r1, d1;
  logic       b0, b1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pulse_stretch_nch #(.CH(4), .STRETCH(6), .RETRIG(0)) u_r0 (
    .clk(clk), .rst(rst), .din(din), .drop_clr(drop_clr),
    .stretch_out(s0), .rise_out(r0), .drop_flag(d0), .busy(b0)
  );

  pulse_stretch_nch #(.CH(4), .STRETCH(6), .RETRIG(1)) u_r1 (
    .clk(clk), .rst(rst), .din(din), .drop_clr(drop_clr),
    .stretch_out(s1), .rise_out(r1), .drop_flag(d1), .busy(b1)
  );

  typedef struct {
    logic       r;
    logic [3:0] d, c;
    logic [3:0] es0, er0, ed0;
    logic       eb0;
    logic [3:0] es1, er1;
    logic       eb1;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, k, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs produced by that clock edge.
  task automatic cyc(input string nm, input int k, input logic r, input logic [3:0] d, input logic [3:0] c,
                     input logic [3:0] es0, input logic [3:0] er0, input logic [3:0] ed0, input logic eb0,
                     input logic [3:0] es1, input logic [3:0] er1, input logic eb1);
    rst      = r;
    din      = d;
    drop_clr = c;
    @(posedge clk);
    #1;
    chk({nm, " stretch r0"}, k, s0, es0);
    chk({nm, " rise r0"},    k, r0, er0);
    chk({nm, " drop r0"},    k, d0, ed0);
    chk({nm, " busy r0"},    k, {3'b0, b0}, {3'b0, eb0});
    chk({nm, " stretch r1"}, k, s1, es1);
    chk({nm, " rise r1"},    k, r1, er1);
    chk({nm, " drop r1"},    k, d1, 4'b0);
    chk({nm, " busy r1"},    k, {3'b0, b1}, {3'b0, eb1});
  endtask

  initial begin
    rst      = 1'b1;
    din      = '0;
    drop_clr = '0;

`ifndef PSTR_INPUT_SYNC_EN
    // Vector j is sampled at edge j; expected outputs are those of cycle j+1.
    // ch0: pulse at 10; ch1: pulses at 10 and 13, drop_clr at 20; ch2: held high 5..24.
    for (int j = 0; j < 26; j++) begin
      tbl[j]        = '{r: 1'b0, d: 4'b0, c: 4'b0, es0: 4'b0, er0: 4'b0, ed0: 4'b0, eb0: 1'b0,
                        es1: 4'b0, er1: 4'b0, eb1: 1'b0};
      tbl[j].r      = (j < 2);
      tbl[j].d[0]   = (j == 10);
      tbl[j].d[1]   = (j == 10) || (j == 13);
      tbl[j].d[2]   = (j >= 5) && (j <= 24);
      tbl[j].c[1]   = (j == 20);
      tbl[j].es0[0] = (j >= 10) && (j <= 15);
      tbl[j].es0[1] = (j >= 10) && (j <= 15);
      tbl[j].es0[2] = (j >= 5) && (j <= 10);
      tbl[j].er0[0] = (j == 10);
      tbl[j].er0[1] = (j == 10);
      tbl[j].er0[2] = (j == 5);
      tbl[j].ed0[1] = (j >= 13) && (j <= 19);
      tbl[j].eb0    = (j >= 5) && (j <= 15);
      tbl[j].es1[0] = (j >= 10) && (j <= 15);
      tbl[j].es1[1] = (j >= 10) && (j <= 18);
      tbl[j].es1[2] = (j >= 5) && (j <= 10);
      tbl[j].er1[0] = (j == 10);
      tbl[j].er1[1] = (j == 10) || (j == 13);
      tbl[j].er1[2] = (j == 5);
      tbl[j].eb1    = (j >= 5) && (j <= 18);
    end

    for (int j = 0; j < 26; j++)
      cyc("tbl", j, tbl[j].r, tbl[j].d, tbl[j].c, tbl[j].es0, tbl[j].er0, tbl[j].ed0, tbl[j].eb0,
          tbl[j].es1, tbl[j].er1, tbl[j].eb1);

    // Second edge on ch1 lands on cnt==1, together with drop_clr: set must win; clear two cycles later.
    for (int k = 0; k < 13; k++)
      cyc("cnt1", k, 1'b0, {2'b0, (k == 0) || (k == 6), 1'b0}, {2'b0, (k == 6) || (k == 8), 1'b0},
          {2'b0, k <= 5, 1'b0}, {2'b0, k == 0, 1'b0}, {2'b0, (k == 6) || (k == 7), 1'b0}, k <= 5,
          {2'b0, k <= 11, 1'b0}, {2'b0, (k == 0) || (k == 6), 1'b0}, k <= 11);

    // din[2] already high while in reset; first non-reset edge counts as a rising edge.
    for (int k = 0; k < 13; k++)
      cyc("rstrel", k, k < 3, {1'b0, k <= 10, 2'b0}, 4'b0,
          {1'b0, (k >= 3) && (k <= 8), 2'b0}, {1'b0, k == 3, 2'b0}, 4'b0, (k >= 3) && (k <= 8),
          {1'b0, (k >= 3) && (k <= 8), 2'b0}, {1'b0, k == 3, 2'b0}, (k >= 3) && (k <= 8));

    // All channels stretching with drop flags set, then reset truncates everything.
    for (int k = 0; k < 7; k++)
      cyc("midrst", k, k == 3, ((k == 0) || (k == 2)) ? 4'hF : 4'h0, 4'b0,
          (k <= 2) ? 4'hF : 4'h0, (k == 0) ? 4'hF : 4'h0, (k == 2) ? 4'hF : 4'h0, k <= 2,
          (k <= 2) ? 4'hF : 4'h0, ((k == 0) || (k == 2)) ? 4'hF : 4'h0, k <= 2);
`else
    // Synchronised input: pulse on din[3] before edge 0 shows up two cycles later.
    for (int k = 0; k < 2; k++)
      cyc("syncrst", k, 1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 4'b0, 4'b0, 1'b0);
    for (int k = 0; k < 11; k++)
      cyc("sync", k, 1'b0, {k == 0, 3'b0}, 4'b0,
          {(k >= 2) && (k <= 7), 3'b0}, {k == 2, 3'b0}, 4'b0, (k >= 2) && (k <= 7),
          {(k >= 2) && (k <= 7), 3'b0}, {k == 2, 3'b0}, (k >= 2) && (k <= 7));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
